uart_fifo_tx: RTL and testbench

- Transmit engine on the read side of the UART byte FIFO.
- Pops bytes through the FIFO read handshake (read_strobe / read_data / empty) and serializes them on the TX line as 8-bit async frames: start, 8 data LSB-first, optional parity, 1 or 2 stops.
- Sits between the TX-direction FIFO instance and the pad.
- Provides flow control (cts), an enable gate, and a runtime baud divisor.

---
 rtl/uart_fifo_tx.sv | 162 ++++++++++++++++
 tb/tb_uart_fifo_tx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_tx.sv
// UART transmit engine on the read side of a byte FIFO: pops one byte per frame
// and serializes start, 8 data bits LSB-first, optional parity and 1 or 2 stop bits.
module uart_fifo_tx #(
  parameter int DIVISOR_WIDTH = 16,
  parameter int PARITY        = 0,
  parameter int STOP_BITS     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DIVISOR_WIDTH-1:0] baud_divisor,
  input  logic                     cts,
  input  logic                     fifo_empty,
  input  logic [7:0]               fifo_read_data,
  output logic                     fifo_read_strobe,
  output logic                     tx,
  output logic                     busy,
  output logic                     byte_done
);

  localparam bit PAR_EN   = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD  = (PARITY == 1);
  localparam bit TWO_STOP = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t                   state, state_n;
  logic [DIVISOR_WIDTH-1:0] cnt, cnt_n, div_q, div_n, div_eff;
  logic [7:0]               shreg, shreg_n;
  logic [2:0]               bit_idx, bit_idx_n;
  logic                     par_bit, par_n;
  logic                     stop_idx, stop_n;
  logic                     tx_n, strobe_n, busy_n, done_n;
  logic                     go, last_cnt;

  assign go       = enable && cts && !fifo_empty;
  assign last_cnt = (cnt == '0);
  assign div_eff  = (baud_divisor == '0) ? {{(DIVISOR_WIDTH-1){1'b0}}, 1'b1} : baud_divisor;

  // Every output is computed from the next state so it can be registered.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    div_n     = div_q;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    par_n     = par_bit;
    stop_n    = stop_idx;
    tx_n      = tx;
    done_n    = 1'b0;
    case (state)
      S_IDLE: begin
        tx_n = 1'b1;
        if (go) state_n = S_ARM;
      end
      S_ARM: begin
        tx_n    = 1'b1;
        state_n = go ? S_FETCH : S_IDLE;
      end
      S_FETCH: begin
        shreg_n = fifo_read_data;
        div_n   = div_eff;
        cnt_n   = div_eff - 1'b1;
        par_n   = PAR_ODD ? ~^fifo_read_data : ^fifo_read_data;
        tx_n    = 1'b0;
        state_n = S_START;
      end
      S_START: begin
        if (last_cnt) begin
          state_n   = S_DATA;
          cnt_n     = div_q - 1'b1;
          bit_idx_n = 3'd0;
          tx_n      = shreg[0];
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (last_cnt) begin
          cnt_n = div_q - 1'b1;
          if (bit_idx == 3'd7) begin
            if (PAR_EN) begin
              state_n = S_PARITY;
              tx_n    = par_bit;
            end else begin
              state_n = S_STOP;
              stop_n  = 1'b0;
              tx_n    = 1'b1;
            end
          end else begin
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_PARITY: begin
        if (last_cnt) begin
          cnt_n   = div_q - 1'b1;
          state_n = S_STOP;
          stop_n  = 1'b0;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      S_STOP: begin
        tx_n = 1'b1;
        if (last_cnt) begin
          if (TWO_STOP && !stop_idx) begin
            stop_n = 1'b1;
            cnt_n  = div_q - 1'b1;
          end else begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        tx_n    = 1'b1;
      end
    endcase
    strobe_n = (state_n == S_FETCH);
    busy_n   = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      div_q            <= '0;
      shreg            <= 8'h00;
      bit_idx          <= 3'd0;
      par_bit          <= 1'b0;
      stop_idx         <= 1'b0;
      tx               <= 1'b1;
      fifo_read_strobe <= 1'b0;
      busy             <= 1'b0;
      byte_done        <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      div_q            <= div_n;
      shreg            <= shreg_n;
      bit_idx          <= bit_idx_n;
      par_bit          <= par_n;
      stop_idx         <= stop_n;
      tx               <= tx_n;
      fifo_read_strobe <= strobe_n;
      busy             <= busy_n;
      byte_done        <= done_n;
    end
  end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: three instances (no parity/1 stop, even/1 stop, odd/2 stop),
// each fed by a small FIFO model, with a line monitor that decodes frames against a queue.
module tb_uart_fifo_tx;

  localparam int PAR [3] = '{0, 2, 1};
  localparam int STP [3] = '{1, 1, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cts = 1'b1;
  logic [15:0] baud = 16'd4;
  logic        en     [3];
  logic        empty  [3];
  logic [7:0]  rdata  [3];
  logic        strobe [3];
  logic        tx     [3];
  logic        busy   [3];
  logic        done   [3];

  logic [7:0]  fmem [3][16];
  int          wp [3];
  int          rp [3];
  int          strobes [3];
  int          underflow = 0;

  // scoreboard entry: {instance[1:0], effective divisor[7:0], byte[7:0]}
  logic [17:0] exp_q[$];
  int          gap_log[$];

  int          n_assert = 0;
  int          n_fail   = 0;
  int          frames_done = 0;
  int          last_len = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_fifo_tx #(.DIVISOR_WIDTH(16), .PARITY(PAR[g]), .STOP_BITS(STP[g])) u_dut (
      .clk              (clk),
      .rst              (rst),
      .enable           (en[g]),
      .baud_divisor     (baud),
      .cts              (cts),
      .fifo_empty       (empty[g]),
      .fifo_read_data   (rdata[g]),
      .fifo_read_strobe (strobe[g]),
      .tx               (tx[g]),
      .busy             (busy[g]),
      .byte_done        (done[g])
    );
    assign empty[g] = (wp[g] == rp[g]);
    assign rdata[g] = fmem[g][rp[g][3:0]];
  end

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_assert++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // FIFO model: pointer moves on the strobe edge, after the DUT has sampled the head.
  initial for (int g = 0; g < 3; g++) begin wp[g] = 0; rp[g] = 0; strobes[g] = 0; end
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (strobe[g]) begin
        strobes[g] <= strobes[g] + 1;
        if (wp[g] == rp[g]) underflow <= underflow + 1;
        else rp[g] <= rp[g] + 1;
      end
    end
  end

  // Line monitor
  logic [11:0] mb [3];
  int          mn [3], mc [3], md [3], mbad [3], idle_c [3];
  bit          act [3];
  logic        prev_strobe [3];
  initial for (int g = 0; g < 3; g++) begin act[g] = 0; idle_c[g] = 0; prev_strobe[g] = 0; end

  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        act[g] = 0;
        idle_c[g] = 0;
      end else if (!act[g]) begin
        if (done[g]) check(1'b0, "spurious_byte_done", 1, 0);
        if (tx[g] == 1'b0) begin
          logic [17:0] e;
          logic [7:0]  b;
          check(prev_strobe[g] == 1'b1, "strobe_before_start", prev_strobe[g], 1);
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_frame", g, -1);
            e = {g[1:0], 8'd1, 8'h00};
          end else begin
            e = exp_q.pop_front();
            check(int'(e[17:16]) == g, "frame_instance", g, int'(e[17:16]));
          end
          b = e[7:0];
          mb[g] = '0;
          mb[g][8:1] = b;
          mn[g] = 9;
          if (PAR[g] == 1) begin mb[g][mn[g]] = ~^b; mn[g]++; end
          if (PAR[g] == 2) begin mb[g][mn[g]] = ^b;  mn[g]++; end
          mb[g][mn[g]] = 1'b1; mn[g]++;
          if (STP[g] == 2) begin mb[g][mn[g]] = 1'b1; mn[g]++; end
          md[g] = int'(e[15:8]);
          mc[g] = 1;
          mbad[g] = 0;
          gap_log.push_back(idle_c[g]);
          act[g] = 1;
        end else begin
          idle_c[g]++;
        end
      end else if (mc[g] < mn[g] * md[g]) begin
        if (tx[g] != mb[g][mc[g] / md[g]] || !busy[g] || done[g]) mbad[g]++;
        mc[g]++;
      end else begin
        check(mbad[g] == 0, "frame_bits", mbad[g], 0);
        check(done[g] == 1'b1 && tx[g] == 1'b1, "byte_done_pulse", done[g], 1);
        last_len = mc[g];
        frames_done++;
        act[g] = 0;
        idle_c[g] = 1;
      end
      prev_strobe[g] = strobe[g];
    end
  end

  task automatic push_byte(input int g, input logic [7:0] b, input int d);
    int deff;
    deff = (d == 0) ? 1 : d;
    fmem[g][wp[g][3:0]] = b;
    wp[g] = wp[g] + 1;
    exp_q.push_back({g[1:0], deff[7:0], b});
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin @(negedge clk); n++; end
    check(frames_done >= target, "frame_timeout", frames_done, target);
  endtask

  task automatic wait_strobe(input int g, input int target, input int budget);
    int n = 0;
    while (strobes[g] < target && n < budget) begin @(negedge clk); n++; end
    check(strobes[g] >= target, "strobe_timeout", strobes[g], target);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         d;
    int         len;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int s0, f0, bad, n;
    for (int g = 0; g < 3; g++) en[g] = 1'b1;

    vecs[0] = '{0, 8'h55, 4, 40};
    vecs[1] = '{1, 8'h07, 2, 22};
    vecs[2] = '{2, 8'h07, 2, 24};
    vecs[3] = '{0, 8'h3C, 0, 10};
    vecs[4] = '{1, 8'hFF, 3, 33};
    vecs[5] = '{2, 8'h00, 1, 12};
    vecs[6] = '{1, 8'hA6, 5, 55};

    // reset values
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++)
      check(tx[g] == 1'b1 && busy[g] == 1'b0 && strobe[g] == 1'b0 && done[g] == 1'b0,
            "reset_outputs", {tx[g], busy[g], strobe[g], done[g]}, 4'b1000);
    rst = 1'b0;

    // empty FIFO: nothing happens for 100 clocks
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) if (tx[g] != 1'b1 || strobe[g] || busy[g]) bad++;
    end
    check(bad == 0, "idle_with_empty_fifo", bad, 0);

    // single-frame vectors
    for (int i = 0; i < 7; i++) begin
      baud = vecs[i].d[15:0];
      s0 = strobes[vecs[i].inst];
      f0 = frames_done;
      push_byte(vecs[i].inst, vecs[i].data, vecs[i].d);
      wait_frames(f0 + 1, 400);
      check(strobes[vecs[i].inst] - s0 == 1, "one_strobe_per_frame", strobes[vecs[i].inst] - s0, 1);
      check(last_len == vecs[i].len, "frame_length", last_len, vecs[i].len);
    end

    // three queued bytes back to back
    baud = 16'd3;
    gap_log.delete();
    s0 = strobes[0];
    f0 = frames_done;
    push_byte(0, 8'hA1, 3);
    push_byte(0, 8'hB2, 3);
    push_byte(0, 8'hC3, 3);
    wait_frames(f0 + 3, 300);
    check(strobes[0] - s0 == 3, "three_strobes", strobes[0] - s0, 3);
    check(gap_log.size() == 3 && gap_log[1] == 3, "gap_frame2", gap_log.size() > 1 ? gap_log[1] : -1, 3);
    check(gap_log.size() == 3 && gap_log[2] == 3, "gap_frame3", gap_log.size() > 2 ? gap_log[2] : -1, 3);

    // flow control: cts then enable dropped mid-frame
    for (int k = 0; k < 2; k++) begin
      baud = 16'd4;
      s0 = strobes[0];
      f0 = frames_done;
      push_byte(0, 8'h5A + k[7:0], 4);
      push_byte(0, 8'hC6 - k[7:0], 4);
      wait_strobe(0, s0 + 1, 50);
      repeat (6) @(negedge clk);
      if (k == 0) cts = 1'b0; else en[0] = 1'b0;
      wait_frames(f0 + 1, 100);
      repeat (50) @(negedge clk);
      check(strobes[0] - s0 == 1, "held_off_strobe", strobes[0] - s0, 1);
      check(frames_done == f0 + 1, "held_off_frames", frames_done - f0, 1);
      if (k == 0) cts = 1'b1; else en[0] = 1'b1;
      n = 0;
      while (!strobe[0] && n < 10) begin @(negedge clk); n++; end
      check(strobe[0] && n <= 2, "strobe_after_release", n, 2);
      wait_frames(f0 + 2, 100);
    end

    // divisor change mid-frame only applies to the next frame
    baud = 16'd4;
    s0 = strobes[0];
    f0 = frames_done;
    push_byte(0, 8'h93, 4);
    push_byte(0, 8'h2E, 8);
    wait_strobe(0, s0 + 1, 50);
    repeat (10) @(negedge clk);
    baud = 16'd8;
    wait_frames(f0 + 1, 100);
    check(last_len == 40, "len_before_change", last_len, 40);
    wait_frames(f0 + 2, 200);
    check(last_len == 80, "len_after_change", last_len, 80);

    // reset pulsed mid-DATA
    baud = 16'd4;
    s0 = strobes[0];
    f0 = frames_done;
    push_byte(0, 8'h0F, 4);
    wait_strobe(0, s0 + 1, 50);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    #1;
    check(tx[0] == 1'b1 && busy[0] == 1'b0, "async_reset_mid_frame", {tx[0], busy[0]}, 2'b10);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check(strobes[0] - s0 == 1, "no_refetch_after_reset", strobes[0] - s0, 1);
    check(frames_done == f0, "aborted_frame_not_done", frames_done - f0, 0);

    check(underflow == 0, "fifo_underflow", underflow, 0);
    check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1, required 0");
    $fatal(1, "timeout");
  end

endmodule
